// File: rtl/vmx_row_feeder.sv
`default_nettype none
// ============================================================================
// Module      : vmx_row_feeder
// Description : Stream-to-systolic-array front end for the VMX PE chain.
//               Loads one tagged weight per PE, forwards activation words,
//               then flushes the chain with zero bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module vmx_row_feeder #(
    parameter int DATA_W = 16,
    parameter int MAX_PE = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        num_pe,
    input  logic              simd_mode_cfg,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] pe_data,
    output logic [7:0]        pe_load_ctrl,
    output logic              pe_simd_mode,
    output logic              pe_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  beat_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    // 8'h7F decrements away from 8'h80 in every PE, so it never loads a weight
    localparam logic [7:0] c_tag_bubble = 8'h7F;
    localparam logic [7:0] c_tag_load   = 8'h80;
    localparam logic [6:0] c_max_pe     = 7'(MAX_PE);

    state_t             state_q, state_d;
    logic [6:0]         n_q, n_d;
    logic [5:0]         w_q, w_d;
    logic [6:0]         f_q, f_d;
    logic               mode_q, mode_d;
    logic [DATA_W-1:0]  pe_data_q, pe_data_d;
    logic [7:0]         pe_ctrl_q, pe_ctrl_d;
    logic               pe_valid_q, pe_valid_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   beat_q, beat_d;

    logic               w_hs;
    logic [6:0]         w_n_clamped;

    assign s_ready      = (state_q == S_LOAD) || (state_q == S_STREAM);
    assign w_hs         = s_valid & s_ready;
    assign busy         = (state_q != S_IDLE);
    assign pe_data      = pe_data_q;
    assign pe_load_ctrl = pe_ctrl_q;
    assign pe_simd_mode = mode_q;
    assign pe_valid     = pe_valid_q;
    assign done         = done_q;
    assign beat_count   = beat_q;

    // Chain length for a new job: 0 behaves as 1, oversize requests cap at MAX_PE
    always_comb begin
        w_n_clamped = num_pe;
        if (num_pe == 7'd0) begin
            w_n_clamped = 7'd1;
        end else if (num_pe > c_max_pe) begin
            w_n_clamped = c_max_pe;
        end
    end

    // Next-state and next-output logic; every non-handshake cycle is a bubble
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        w_d        = w_q;
        f_d        = f_q;
        mode_d     = mode_q;
        beat_d     = beat_q;
        pe_data_d  = '0;
        pe_ctrl_d  = c_tag_bubble;
        pe_valid_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = w_n_clamped;
                    mode_d  = simd_mode_cfg;
                    beat_d  = '0;
                    w_d     = 6'(w_n_clamped - 7'd1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_hs) begin
                    // Farthest PE first so the tag count-down lands on each PE in turn
                    pe_data_d = s_data;
                    pe_ctrl_d = c_tag_load | {2'b00, w_q};
                    if (w_q == 6'd0) begin
                        state_d = S_STREAM;
                    end else begin
                        w_d = w_q - 6'd1;
                    end
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    pe_data_d  = s_data;
                    pe_valid_d = 1'b1;
                    if (beat_q != {CNT_W{1'b1}}) begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                    if (s_last) begin
                        f_d     = n_q;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                f_d = f_q - 7'd1;
                if (f_q == 7'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= 7'd1;
            w_q        <= 6'd0;
            f_q        <= 7'd0;
            mode_q     <= 1'b0;
            pe_data_q  <= '0;
            pe_ctrl_q  <= c_tag_bubble;
            pe_valid_q <= 1'b0;
            done_q     <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            w_q        <= w_d;
            f_q        <= f_d;
            mode_q     <= mode_d;
            pe_data_q  <= pe_data_d;
            pe_ctrl_q  <= pe_ctrl_d;
            pe_valid_q <= pe_valid_d;
            done_q     <= done_d;
            beat_q     <= beat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vmx_row_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmx_row_feeder
// Description : Directed self-checking bench for vmx_row_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vmx_row_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  num_pe;
    logic        simd_mode_cfg;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic [15:0] pe_data;
    logic [7:0]  pe_load_ctrl;
    logic        pe_simd_mode;
    logic        pe_valid;
    logic        busy;
    logic        done;
    logic [15:0] beat_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] pe_w [0:63];

    vmx_row_feeder #(.DATA_W(16), .MAX_PE(64), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_pe       (num_pe),
        .simd_mode_cfg(simd_mode_cfg),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .pe_data      (pe_data),
        .pe_load_ctrl (pe_load_ctrl),
        .pe_simd_mode (pe_simd_mode),
        .pe_valid     (pe_valid),
        .busy         (busy),
        .done         (done),
        .beat_count   (beat_count)
    );

    always #5 clk = ~clk;

    // Time bound on the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        check({tag, "_ctrl"}, 32'(pe_load_ctrl), 32'h7F);
        check({tag, "_vld"}, 32'(pe_valid), 32'h0);
        check({tag, "_data"}, 32'(pe_data), 32'h0);
    endtask

    // Downstream chain model: PE j sees the tag after j decrements, loads on 8'h80
    task automatic capture();
        for (int j = 0; j < 64; j++) begin
            if (8'(pe_load_ctrl - 8'(j)) == 8'h80) pe_w[j] = pe_data;
        end
    endtask

    // One complete job; returns in the cycle where done is observed
    task automatic do_job(input int ncfg, input bit mode, input int nexp,
                          input int nact, input bit stall, input bit noise);
        int cnt;
        int guard;
        num_pe = 7'(ncfg);
        simd_mode_cfg = mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'h1);
        check("start_rdy", 32'(s_ready), 32'h1);
        check("start_done", 32'(done), 32'h0);
        check("start_beat", 32'(beat_count), 32'h0);
        if (noise) begin
            simd_mode_cfg = ~mode;
            num_pe = 7'd5;
        end
        for (int i = 0; i < nexp; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h1000 + 16'(i);
            if (noise && i == 0) start = 1'b1;
            tick();
            start = 1'b0;
            capture();
            check("w_ctrl", 32'(pe_load_ctrl), 32'(8'h80 | 8'(nexp - 1 - i)));
            check("w_data", 32'(pe_data), 32'(16'h1000 + 16'(i)));
            check("w_vld", 32'(pe_valid), 32'h0);
            check("w_mode", 32'(pe_simd_mode), 32'(mode));
            if (stall) begin
                s_valid = 1'b0;
                tick();
                chk_bubble("w_stall");
            end
        end
        for (int i = 0; i < nact; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h2000 + 16'(i);
            s_last  = (i == nact - 1);
            if (noise && i == 0) start = 1'b1;
            tick();
            start = 1'b0;
            check("a_vld", 32'(pe_valid), 32'h1);
            check("a_ctrl", 32'(pe_load_ctrl), 32'h7F);
            check("a_data", 32'(pe_data), 32'(16'h2000 + 16'(i)));
            check("a_beat", 32'(beat_count), 32'(i + 1));
            check("a_mode", 32'(pe_simd_mode), 32'(mode));
            if (stall && i != nact - 1) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                tick();
                chk_bubble("a_stall");
                check("a_hold", 32'(beat_count), 32'(i + 1));
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        cnt   = 0;
        guard = 0;
        if (noise) start = 1'b1;
        while (!done && guard < 1000) begin
            if (busy && !s_ready) cnt++;
            check("f_mode", 32'(pe_simd_mode), 32'(mode));
            tick();
            start = 1'b0;
            guard++;
        end
        check("flush_len", 32'(cnt), 32'(nexp));
        check("done", 32'(done), 32'h1);
        check("done_busy", 32'(busy), 32'h0);
        check("done_beat", 32'(beat_count), 32'(nact));
        check("done_mode", 32'(pe_simd_mode), 32'(mode));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_pe = 7'd0;
        simd_mode_cfg = 1'b0;
        s_valid = 1'b0;
        s_data = 16'h0;
        s_last = 1'b0;
        for (int j = 0; j < 64; j++) pe_w[j] = 16'hDEAD;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ctrl", 32'(pe_load_ctrl), 32'h7F);
        check("rst_vld", 32'(pe_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rdy", 32'(s_ready), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_beat", 32'(beat_count), 32'h0);
        check("rst_data", 32'(pe_data), 32'h0);
        check("rst_mode", 32'(pe_simd_mode), 32'h0);

        // Four weights back-to-back land on PE3..PE0 in order
        do_job(4, 1'b0, 4, 1, 1'b0, 1'b0);
        check("pe3_w", 32'(pe_w[3]), 32'h1000);
        check("pe2_w", 32'(pe_w[2]), 32'h1001);
        check("pe1_w", 32'(pe_w[1]), 32'h1002);
        check("pe0_w", 32'(pe_w[0]), 32'h1003);
        tick();
        check("pulse1", 32'(done), 32'h0);
        check("idle_bubble", 32'(pe_load_ctrl), 32'h7F);

        // Stalled stream with a two-PE chain
        do_job(2, 1'b0, 2, 3, 1'b1, 1'b0);
        tick();
        check("pulse2", 32'(done), 32'h0);

        // Clamp at both ends; second job starts in the cycle after done
        do_job(0, 1'b0, 1, 1, 1'b0, 1'b0);
        do_job(100, 1'b0, 64, 2, 1'b0, 1'b0);
        check("pe63_w", 32'(pe_w[63]), 32'h1000);
        check("pe0_w64", 32'(pe_w[0]), 32'h103F);
        tick();
        check("pulse3", 32'(done), 32'h0);

        // SIMD mode latched; starts and config changes mid-job are ignored
        do_job(2, 1'b1, 2, 2, 1'b0, 1'b1);
        tick();
        check("pulse4", 32'(done), 32'h0);
        check("idle_busy4", 32'(busy), 32'h0);
        check("idle_mode_hold", 32'(pe_simd_mode), 32'h1);

        // Reset in the middle of STREAM
        num_pe = 7'd2;
        simd_mode_cfg = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h3000 + 16'(i);
            tick();
        end
        check("mid_vld", 32'(pe_valid), 32'h1);
        check("mid_beat", 32'(beat_count), 32'h1);
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mrst_ctrl", 32'(pe_load_ctrl), 32'h7F);
        check("mrst_vld", 32'(pe_valid), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_rdy", 32'(s_ready), 32'h0);
        check("mrst_beat", 32'(beat_count), 32'h0);
        check("mrst_mode", 32'(pe_simd_mode), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_done", 32'(done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
